// File: rtl/mem_dump_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : mem_dump_reader_pkg                                        |
// | Brief  : Shared memory-port encodings and dump FSM state encoding   |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
package mem_dump_reader_pkg;

    // Data-memory read-enable codes (only two are ever driven by the dumper)
    localparam logic [1:0] READ_DISABLE  = 2'b00;
    localparam logic [1:0] READ_WORD     = 2'b11;

    // Data-memory write-enable code; the dumper never writes
    localparam logic [1:0] WRITE_DISABLE = 2'b00;

    // Dump sequencer states
    typedef enum logic [2:0] {
        MDR_IDLE  = 3'd0,
        MDR_REQ   = 3'd1,
        MDR_LATCH = 3'd2,
        MDR_SEND  = 3'd3,
        MDR_DONE  = 3'd4
    } mdr_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_dump_reader_word_byte_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : word_byte_serializer                                       |
// | Brief  : Holds one memory word and emits it LSB byte first over a   |
// |          valid/ready stream; flags acceptance of the final byte     |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
module word_byte_serializer #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [NB_DATA-1:0] load_word,
    input  logic               send,
    input  logic               ready,
    output logic               valid,
    output logic [NB_BYTE-1:0] data,
    output logic               last_accepted
);

    localparam int NUM_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_BCNT   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NUM_BYTES - 1);

    logic [NB_DATA-1:0] word_q;
    logic [NB_BCNT-1:0] bcnt;
    logic               fire;

    // Valid follows the sequencer's SEND state, so it can never be retracted
    // before the handshake completes; data only moves when bcnt advances.
    assign valid         = send;
    assign fire          = send & ready;
    assign data          = word_q[int'(bcnt) * NB_BYTE +: NB_BYTE];
    assign last_accepted = fire && (bcnt == LAST_BYTE);

    // Word capture and byte index: a load restarts at byte 0, each accepted byte advances
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            bcnt   <= '0;
        end else if (load) begin
            word_q <= load_word;
            bcnt   <= '0;
        end else if (fire) begin
            bcnt <= (bcnt == LAST_BYTE) ? '0 : bcnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_dump_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : mem_dump_reader                                            |
// | Brief  : Debug-unit read initiator: walks data-memory words 0..N-1  |
// |          and streams each word LSB byte first towards the UART      |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int NB_DEPTH = 10,
    parameter int NB_DATA  = 32,
    parameter int NB_BYTE  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [NB_DEPTH:0]   i_num_words,
    output logic [NB_DEPTH-1:0] o_mem_addr,
    output logic [1:0]          o_mem_read_enable,
    output logic [1:0]          o_mem_write_enable,
    input  logic [NB_DATA-1:0]  i_mem_data,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_busy,
    output logic                o_done
);

    // Word count ceiling: the whole memory, 2**NB_DEPTH words
    localparam logic [NB_DEPTH:0] MAX_WORDS = {1'b1, {NB_DEPTH{1'b0}}};

    mdr_state_t          state;
    mdr_state_t          state_next;
    logic [NB_DEPTH:0]   num_q;
    logic [NB_DEPTH:0]   num_clamped;
    logic [NB_DEPTH-1:0] addr;
    logic                last_word;
    logic                load;
    logic                send;
    logic                last_accepted;

    // Requests beyond the memory size are trimmed so the address never wraps
    assign num_clamped = (i_num_words > MAX_WORDS) ? MAX_WORDS : i_num_words;

    // Current address is the final one when addr+1 reaches the latched count
    assign last_word = (({1'b0, addr} + 1'b1) == num_q);

    assign o_mem_addr         = addr;
    assign o_mem_write_enable = WRITE_DISABLE;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= MDR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Word count capture at start and address advance after each word's last byte
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            num_q <= '0;
            addr  <= '0;
        end else if ((state == MDR_IDLE) && i_start) begin
            num_q <= num_clamped;
            addr  <= '0;
        end else if ((state == MDR_SEND) && last_accepted && !last_word) begin
            addr <= addr + 1'b1;
        end
    end

    // Next-state and decoded outputs; read enable is a one-cycle pulse in REQ
    always_comb begin
        state_next        = state;
        o_mem_read_enable = READ_DISABLE;
        load              = 1'b0;
        send              = 1'b0;
        o_busy            = 1'b1;
        o_done            = 1'b0;
        case (state)
            MDR_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_next = (num_clamped == '0) ? MDR_DONE : MDR_REQ;
                end
            end
            MDR_REQ: begin
                o_mem_read_enable = READ_WORD;
                state_next        = MDR_LATCH;
            end
            MDR_LATCH: begin
                load       = 1'b1;
                state_next = MDR_SEND;
            end
            MDR_SEND: begin
                send = 1'b1;
                if (last_accepted) begin
                    state_next = last_word ? MDR_DONE : MDR_REQ;
                end
            end
            MDR_DONE: begin
                o_done     = 1'b1;
                state_next = MDR_IDLE;
            end
            default: begin
                state_next = MDR_IDLE;
            end
        endcase
    end

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clk           (i_clk),
        .rst_n         (i_rst_n),
        .load          (load),
        .load_word     (i_mem_data),
        .send          (send),
        .ready         (i_tx_ready),
        .valid         (o_tx_valid),
        .data          (o_tx_data),
        .last_accepted (last_accepted)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_mem_dump_reader                                         |
// | Brief  : Self-checking bench for mem_dump_reader with a registered  |
// |          memory and a byte-queue reference of the expected dump     |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_mem_dump_reader;
    import mem_dump_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] num_words;
    logic [9:0]  mem_addr;
    logic [1:0]  mem_re;
    logic [1:0]  mem_we;
    logic [31:0] mem_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] bram [0:1023];

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;

    // Reference model state: bytes still expected, reads expected, observed events
    logic [7:0] exp_q [$];
    int  rd_cnt, exp_rd_addr, max_addr, done_cnt, done_cyc, first_valid;
    int  valid_cycles, acc_cnt, pat, start_cyc;
    bit  prev_hold = 1'b0;
    bit  prev_re_word = 1'b0;
    logic [7:0] prev_data = '0;

    mem_dump_reader dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_start            (start),
        .i_num_words        (num_words),
        .o_mem_addr         (mem_addr),
        .o_mem_read_enable  (mem_re),
        .o_mem_write_enable (mem_we),
        .i_mem_data         (mem_data),
        .o_tx_data          (tx_data),
        .o_tx_valid         (tx_valid),
        .i_tx_ready         (tx_ready),
        .o_busy             (busy),
        .o_done             (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered data memory: word appears the cycle after a READ_WORD request
    always @(posedge clk) begin
        if (mem_re == READ_WORD) mem_data <= bram[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic next_ready(input int mode);
        logic r;
        case (mode)
            0:       r = 1'b1;
            1:       r = ((pat % 3) == 0);
            default: r = ($urandom_range(0, 3) != 0);
        endcase
        pat++;
        return r;
    endfunction

    // Protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold    <= 1'b0;
            prev_re_word <= 1'b0;
        end else begin
            check("write_enable", mem_we, WRITE_DISABLE);
            check("re_legal", (mem_re === READ_WORD) || (mem_re === READ_DISABLE), 1);
            if (mem_re === READ_WORD) begin
                check("re_single_pulse", prev_re_word, 0);
                check("read_addr", mem_addr, exp_rd_addr);
                exp_rd_addr = exp_rd_addr + 1;
                rd_cnt      = rd_cnt + 1;
                if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            end
            if (prev_hold) begin
                check("valid_held", tx_valid, 1);
                check("data_stable", tx_data, prev_data);
            end
            if (tx_valid) begin
                valid_cycles = valid_cycles + 1;
                if (first_valid < 0) first_valid = cyc;
                if (tx_ready) begin
                    acc_cnt = acc_cnt + 1;
                    if (exp_q.size() == 0) check("extra_byte", tx_data, 'x);
                    else check("byte", tx_data, exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                check("busy_in_done", busy, 1);
            end
            prev_hold    <= tx_valid && !tx_ready;
            prev_data    <= tx_data;
            prev_re_word <= (mem_re === READ_WORD);
        end
    end

    task automatic clear_model(input int n);
        exp_q.delete();
        for (int w = 0; w < n; w++)
            for (int b = 0; b < 4; b++) exp_q.push_back(bram[w][8*b +: 8]);
        rd_cnt = 0; exp_rd_addr = 0; max_addr = 0; done_cnt = 0; done_cyc = -1;
        first_valid = -1; valid_cycles = 0; acc_cnt = 0; pat = 0;
    endtask

    task automatic run_dump(input int num, input int mode, input bit inject);
        int n, t;
        bit timed_out;
        n = (num > 1024) ? 1024 : num;
        clear_model(n);
        num_words = 11'(num);
        start     = 1'b1;
        tx_ready  = next_ready(mode);
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        num_words = 11'($urandom);
        t = 0; timed_out = 0;
        while (done_cnt == 0) begin
            if (t >= 30000) begin timed_out = 1; break; end
            tx_ready = next_ready(mode);
            if (inject && t == 5) begin start = 1'b1; num_words = 11'd1; end
            if (inject && t == 6) start = 1'b0;
            @(posedge clk); #1;
            t++;
        end
        check("done_timeout", timed_out, 0);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("bytes_missing", exp_q.size(), 0);
        check("read_count", rd_cnt, n);
        check("done_pulses", done_cnt, 1);
        if (n > 0) begin
            check("first_valid_latency", first_valid - start_cyc, 2);
            check("max_addr", max_addr, n - 1);
            if (mode == 0) check("done_latency_full_rate", done_cyc - start_cyc, 6 * n);
        end else begin
            check("done_latency_empty", done_cyc - start_cyc, 0);
            check("no_valid_empty", valid_cycles, 0);
        end
        tx_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_re"}, mem_re, READ_DISABLE);
        check({tag, "_we"}, mem_we, WRITE_DISABLE);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; start = 1'b0; num_words = '0; tx_ready = 1'b0;
        for (int i = 0; i < 1024; i++) bram[i] = $urandom;
        clear_model(0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: two known words, sink always ready
        bram[0] = 32'h11223344;
        bram[1] = 32'hA5A50F0F;
        run_dump(2, 0, 1'b0);

        // 2: same words under 1,0,0 ready pattern
        run_dump(2, 1, 1'b0);

        // 3: empty dump
        run_dump(0, 0, 1'b0);

        // 4a: start pulse during a dump is ignored
        for (int i = 0; i < 4; i++) bram[i] = $urandom;
        run_dump(4, 0, 1'b1);

        // 4b: reset while byte index 2 of the first word is offered
        clear_model(3);
        num_words = 11'd3; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (acc_cnt < 2 && t < 50) begin @(posedge clk); #1; t++; end
        check("reach_byte2", acc_cnt, 2);
        tx_ready = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_dump(3, 2, 1'b0);

        // 5: full memory with address pattern
        for (int i = 0; i < 1024; i++) bram[i] = i;
        run_dump(1024, 0, 1'b0);
        check("last_word_value", bram[1023], 32'h000003FF);

        // 6: oversized request is clamped, random data and backpressure
        for (int i = 0; i < 1024; i++) bram[i] = $urandom;
        run_dump(2047, 2, 1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
`default_nettype wire
